fifo_write_arb_ctrl: RTL and testbench

//   Write-domain controller and arbiter for the async FIFO write memory.

---
 rtl/fifo_write_arb_ctrl_if.sv | 27 ++
 rtl/fifo_write_arb_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_write_arb_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arb_ctrl_if.sv
// fifo_write_arb_ctrl_if: requester, pointer and memory-write-port bundle for the FIFO write arbiter
interface fifo_write_arb_ctrl_if #(
    parameter int D_SIZE = 16,
    parameter int P_SIZE = 3,
    parameter int N_REQ  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*D_SIZE-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [P_SIZE-1:0]       r_ptr_gray;
    logic [P_SIZE-1:0]       w_ptr_gray;
    logic                    w_full;
    logic [P_SIZE-1:0]       w_level;
    logic                    w_inc;
    logic [P_SIZE-2:0]       w_addr;
    logic [D_SIZE-1:0]       w_data;

    modport master (
        output req_valid, req_data, r_ptr_gray,
        input  req_ready, w_ptr_gray, w_full, w_level, w_inc, w_addr, w_data
    );

    modport slave (
        input  req_valid, req_data, r_ptr_gray,
        output req_ready, w_ptr_gray, w_full, w_level, w_inc, w_addr, w_data
    );
endinterface

// File: rtl/fifo_write_arb_ctrl.sv
// fifo_write_arb_ctrl: round-robin write arbiter, write pointer, read-pointer sync and full/level for an async FIFO
module fifo_write_arb_ctrl #(
    parameter int D_SIZE  = 16,
    parameter int F_DEPTH = 4,
    parameter int P_SIZE  = 3,
    parameter int N_REQ   = 2
) (
    input logic                  w_clk,
    input logic                  w_rstn,
    fifo_write_arb_ctrl_if.slave bus
);
    localparam int A_SIZE = $clog2(F_DEPTH);
    localparam int RR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [P_SIZE-1:0] r_bin, r_gray, r_rq1, r_rq2, r_level;
    logic              r_full;
    logic [RR_W-1:0]   r_rr;

    logic [N_REQ-1:0]  w_grant, w_ready;
    logic [RR_W-1:0]   w_gidx;
    logic [D_SIZE-1:0] w_wdata;
    logic              w_wr;
    logic [P_SIZE-1:0] w_bin_nxt, w_gray_nxt, w_rq2_bin;
    logic              w_full_nxt;

    function automatic logic [P_SIZE-1:0] gray2bin(input logic [P_SIZE-1:0] g);
        logic [P_SIZE-1:0] b;
        b = g;
        for (int i = 1; i < P_SIZE; i++) b = b ^ (g >> i);
        return b;
    endfunction

    // Round-robin search starting at r_rr; grant is forced off while reset is held
    always_comb begin
        int  idx;
        logic found;
        w_grant = '0;
        w_gidx  = '0;
        w_wdata = '0;
        found   = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(r_rr) + k) % N_REQ;
            if (w_rstn && !found && bus.req_valid[idx]) begin
                found          = 1'b1;
                w_grant[idx]   = 1'b1;
                w_gidx         = RR_W'(idx);
            end
        end
        for (int i = 0; i < N_REQ; i++)
            if (w_grant[i]) w_wdata = bus.req_data[i*D_SIZE +: D_SIZE];
    end

    assign w_ready    = w_grant & {N_REQ{~r_full}};
    assign w_wr       = |(bus.req_valid & w_ready);
    assign w_bin_nxt  = r_bin + P_SIZE'(w_wr);
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);
    assign w_rq2_bin  = gray2bin(r_rq2);
    assign w_full_nxt = (w_gray_nxt == {~r_rq2[P_SIZE-1:P_SIZE-2], r_rq2[P_SIZE-3:0]});

    // Two-flop synchroniser for the read-domain Gray pointer
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_rq1 <= '0;
            r_rq2 <= '0;
        end else begin
            r_rq1 <= bus.r_ptr_gray;
            r_rq2 <= r_rq1;
        end
    end

    // Write pointer, full flag and fill level all advance from the same next-pointer value
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_full  <= 1'b0;
            r_level <= '0;
        end else begin
            r_bin   <= w_bin_nxt;
            r_gray  <= w_gray_nxt;
            r_full  <= w_full_nxt;
            r_level <= w_bin_nxt - w_rq2_bin;
        end
    end

    // Round-robin pointer moves past the requester that just transferred, otherwise holds
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn)
            r_rr <= '0;
        else if (w_wr)
            r_rr <= (w_gidx == RR_W'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
    end

    assign bus.req_ready  = w_ready;
    assign bus.w_inc      = w_wr;
    assign bus.w_addr     = r_bin[A_SIZE-1:0];
    assign bus.w_data     = w_wdata;
    assign bus.w_ptr_gray = r_gray;
    assign bus.w_full     = r_full;
    assign bus.w_level    = r_level;
endmodule

// File: tb/tb_fifo_write_arb_ctrl.sv
// tb_fifo_write_arb_ctrl: directed self-checking bench for the FIFO write arbiter/controller
module tb_fifo_write_arb_ctrl;
    logic w_clk = 1'b0;
    logic w_rstn;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_write_arb_ctrl_if #(.D_SIZE(16), .P_SIZE(3), .N_REQ(2)) bus ();

    fifo_write_arb_ctrl #(.D_SIZE(16), .F_DEPTH(4), .P_SIZE(3), .N_REQ(2)) dut (
        .w_clk  (w_clk),
        .w_rstn (w_rstn),
        .bus    (bus)
    );

    always #5 w_clk = ~w_clk;

    function automatic logic [2:0] gray(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.r_ptr_gray = '0;
        w_rstn         = 1'b0;
        repeat (2) @(posedge w_clk);
        #1 w_rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_gray", bus.w_ptr_gray, 0);
        chk("rst_full", bus.w_full, 0);
        chk("rst_level", bus.w_level, 0);
        chk("rst_inc", bus.w_inc, 0);
        chk("rst_ready", bus.req_ready, 0);

        // single write from requester 0
        bus.req_valid = 2'b01;
        bus.req_data  = {16'h0000, 16'hA5A5};
        @(negedge w_clk);
        chk("t1_inc", bus.w_inc, 1);
        chk("t1_addr", bus.w_addr, 0);
        chk("t1_data", bus.w_data, 16'hA5A5);
        chk("t1_ready", bus.req_ready, 2'b01);
        step();
        bus.req_valid = 2'b00;
        chk("t1_gray", bus.w_ptr_gray, 3'b001);
        chk("t1_level", bus.w_level, 1);
        chk("t1_full", bus.w_full, 0);

        // both requesters contend until full
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_data  = {16'h2222, 16'h1111};
        for (int c = 0; c < 4; c++) begin
            @(negedge w_clk);
            chk("t2_ready", bus.req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_addr", bus.w_addr, c);
            chk("t2_data", bus.w_data, (c % 2 == 0) ? 16'h1111 : 16'h2222);
            chk("t2_inc", bus.w_inc, 1);
            step();
        end
        chk("t2_full", bus.w_full, 1);
        chk("t2_level", bus.w_level, 4);
        chk("t2_gray", bus.w_ptr_gray, 3'b110);

        // full blocks writes until the synchronised read pointer moves
        @(negedge w_clk);
        chk("t3_ready_full", bus.req_ready, 0);
        chk("t3_inc_full", bus.w_inc, 0);
        step();
        bus.r_ptr_gray = 3'b001;
        step();
        chk("t3_full_e1", bus.w_full, 1);
        step();
        chk("t3_full_e2", bus.w_full, 1);
        step();
        chk("t3_full_e3", bus.w_full, 0);
        @(negedge w_clk);
        chk("t3_inc", bus.w_inc, 1);
        chk("t3_ready", bus.req_ready, 2'b01);
        chk("t3_addr", bus.w_addr, 0);
        chk("t3_data", bus.w_data, 16'h1111);
        step();
        chk("t3_refull", bus.w_full, 1);
        chk("t3_level", bus.w_level, 4);
        @(negedge w_clk);
        chk("t3_inc_after", bus.w_inc, 0);

        // 12 writes with reader keeping pace; pointer wraps
        do_reset();
        bus.req_valid = 2'b01;
        for (int i = 0; i < 12; i++) begin
            bus.req_data = {16'h0000, 16'h4000 + 16'(i)};
            @(negedge w_clk);
            chk("t4_addr", bus.w_addr, i % 4);
            chk("t4_inc", bus.w_inc, 1);
            chk("t4_full", bus.w_full, 0);
            chk("t4_data", bus.w_data, 16'h4000 + i);
            step();
            bus.r_ptr_gray = gray(3'((i + 1) & 7));
        end
        bus.req_valid = 2'b00;
        chk("t4_gray", bus.w_ptr_gray, 3'b110);
        repeat (3) step();
        chk("t4_level", bus.w_level, 0);
        chk("t4_full_end", bus.w_full, 0);

        // lone requester 1 streams without bubbles
        do_reset();
        bus.req_valid = 2'b10;
        bus.req_data  = {16'hBEEF, 16'h0000};
        for (int c = 0; c < 3; c++) begin
            @(negedge w_clk);
            chk("t5_ready", bus.req_ready, 2'b10);
            chk("t5_inc", bus.w_inc, 1);
            chk("t5_addr", bus.w_addr, c);
            chk("t5_data", bus.w_data, 16'hBEEF);
            step();
        end
        chk("t5_level", bus.w_level, 3);
        bus.req_valid = 2'b00;

        // asynchronous reset in the middle of a burst
        do_reset();
        bus.req_valid = 2'b11;
        bus.req_data  = {16'h2222, 16'h1111};
        step();
        step();
        #2 w_rstn = 1'b0;
        #1;
        chk("t6_inc", bus.w_inc, 0);
        chk("t6_ready", bus.req_ready, 0);
        chk("t6_addr", bus.w_addr, 0);
        chk("t6_data", bus.w_data, 0);
        chk("t6_gray", bus.w_ptr_gray, 0);
        chk("t6_full", bus.w_full, 0);
        chk("t6_level", bus.w_level, 0);
        @(posedge w_clk);
        #1 w_rstn = 1'b1;
        @(negedge w_clk);
        chk("t6_rel_addr", bus.w_addr, 0);
        chk("t6_rel_inc", bus.w_inc, 1);
        chk("t6_rel_ready", bus.req_ready, 2'b01);
        chk("t6_rel_data", bus.w_data, 16'h1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
